// File: rtl/product_bcd_conv_if.sv
// Start/busy/done handshake and result bus between the multiplier and the BCD converter.
// The master drives the convert request; the slave (converter) returns the flags and the result.
interface product_bcd_conv_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output overflow
  );
endinterface

// File: rtl/product_bcd_conv.sv
// Binary-to-packed-BCD converter (double dabble), one bit per clock, BIN_W+1 edges from start to done.
// Starts arriving while busy are dropped; bcd_out/overflow only change on completion or reset.
module product_bcd_conv #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  product_bcd_conv_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               ovf_scr_q, ovf_scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   corrected;
  logic [3:0]         digit;
  logic [BCD_W-1:0]   scratch_shifted;
  logic [BIN_W-1:0]   shift_shifted;
  logic               carry_out;
  logic               last_shift;

  // Add-3 correction on every digit from the pre-shift value, digits are independent.
  always_comb begin
    corrected = '0;
    digit     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = scratch_q[4*i +: 4];
      corrected[4*i +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end
  end

  assign carry_out       = corrected[BCD_W-1];
  assign scratch_shifted = {corrected[BCD_W-2:0], shift_q[BIN_W-1]};
  assign shift_shifted   = {shift_q[BIN_W-2:0], 1'b0};
  assign last_shift      = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    ovf_scr_d = ovf_scr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          shift_d   = bus.bin_in;
          scratch_d = '0;
          ovf_scr_d = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
          busy_d    = 1'b1;
          done_d    = 1'b0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        shift_d   = shift_shifted;
        scratch_d = scratch_shifted;
        ovf_scr_d = ovf_scr_q | carry_out;
        cnt_d     = cnt_q - CNT_W'(1);
        if (last_shift) begin
          bcd_d   = scratch_shifted;
          ovf_d   = ovf_scr_q | carry_out;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_scr_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      ovf_scr_q <= ovf_scr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed bench for the BCD converter: default 3-digit instance plus a 2-digit instance for overflow.
module tb_product_bcd_conv;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  product_bcd_conv_if #(.BIN_W(8), .DIGITS(3)) a_if ();
  product_bcd_conv_if #(.BIN_W(8), .DIGITS(2)) b_if ();

  product_bcd_conv #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  product_bcd_conv #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic busy, input logic done,
                       input logic [11:0] bcd, input logic ovf);
    chk({tag, ".busy"}, 32'(a_if.busy), 32'(busy));
    chk({tag, ".done"}, 32'(a_if.done), 32'(done));
    chk({tag, ".bcd"}, 32'(a_if.bcd_out), 32'(bcd));
    chk({tag, ".ovf"}, 32'(a_if.overflow), 32'(ovf));
  endtask

  task automatic chk_b(input string tag, input logic busy, input logic done,
                       input logic [7:0] bcd, input logic ovf);
    chk({tag, ".busy"}, 32'(b_if.busy), 32'(busy));
    chk({tag, ".done"}, 32'(b_if.done), 32'(done));
    chk({tag, ".bcd"}, 32'(b_if.bcd_out), 32'(bcd));
    chk({tag, ".ovf"}, 32'(b_if.overflow), 32'(ovf));
  endtask

  // One conversion on the 3-digit instance: accept edge, 7 busy edges, completion edge.
  task automatic conv_a(input string tag, input logic [7:0] val, input logic [11:0] old_bcd,
                        input logic [11:0] exp_bcd);
    a_if.start  = 1'b1;
    a_if.bin_in = val;
    step();
    a_if.start  = 1'b0;
    a_if.bin_in = 8'h00;
    chk_a({tag, ".e0"}, 1'b1, 1'b0, old_bcd, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk_a({tag, ".busy_hold"}, 1'b1, 1'b0, old_bcd, 1'b0);
    end
    step();
    chk_a({tag, ".done"}, 1'b0, 1'b1, exp_bcd, 1'b0);
  endtask

  task automatic conv_b(input string tag, input logic [7:0] val, input logic [7:0] exp_bcd,
                        input logic exp_ovf);
    b_if.start  = 1'b1;
    b_if.bin_in = val;
    step();
    b_if.start  = 1'b0;
    chk({tag, ".e0busy"}, 32'(b_if.busy), 32'd1);
    for (int i = 1; i < 8; i++) step();
    chk({tag, ".pre_done"}, 32'(b_if.done), 32'd0);
    step();
    chk_b({tag, ".done"}, 1'b0, 1'b1, exp_bcd, exp_ovf);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_if.start = 1'b0;
    a_if.bin_in = 8'h00;
    b_if.start = 1'b0;
    b_if.bin_in = 8'h00;

    // Reset, then idle
    step();
    step();
    chk_a("reset", 1'b0, 1'b0, 12'h000, 1'b0);
    chk_b("reset_b", 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_a("idle", 1'b0, 1'b0, 12'h000, 1'b0);
    end

    // 15*15 and done stickiness
    conv_a("e1", 8'hE1, 12'h000, 12'h225);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_a("e1_sticky", 1'b0, 1'b1, 12'h225, 1'b0);
    end

    // Sweep, back-to-back starts from DONE
    conv_a("sw00", 8'h00, 12'h225, 12'h000);
    conv_a("sw0f", 8'h0F, 12'h000, 12'h015);
    conv_a("sw63", 8'h63, 12'h015, 12'h099);
    conv_a("swff", 8'hFF, 12'h099, 12'h255);

    // Starts while busy (mid-run and on the completion edge) are ignored
    a_if.start = 1'b1;
    a_if.bin_in = 8'h0F;
    step();
    a_if.start = 1'b0;
    step();
    step();
    a_if.start = 1'b1;
    a_if.bin_in = 8'hFF;
    step();
    a_if.start = 1'b0;
    chk_a("ign_mid", 1'b1, 1'b0, 12'h255, 1'b0);
    for (int i = 4; i < 8; i++) step();
    a_if.start = 1'b1;
    a_if.bin_in = 8'hFF;
    step();
    a_if.start = 1'b0;
    chk_a("ign_done_edge", 1'b0, 1'b1, 12'h015, 1'b0);
    step();
    chk_a("ign_after", 1'b0, 1'b1, 12'h015, 1'b0);
    conv_a("b2b", 8'hFF, 12'h015, 12'h255);

    // Reset mid-conversion aborts
    a_if.start = 1'b1;
    a_if.bin_in = 8'hFF;
    step();
    a_if.start = 1'b0;
    for (int i = 1; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_a("abort", 1'b0, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk_a("abort_idle", 1'b0, 1'b0, 12'h000, 1'b0);
    conv_a("x2a", 8'h2A, 12'h000, 12'h042);

    // Two-digit instance: overflow and largest fitting value
    conv_b("d2ff", 8'hFF, 8'h55, 1'b1);
    conv_b("d263", 8'h63, 8'h99, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/product_bcd_conv.md
Name: product_bcd_conv

Overview:
Downstream stage of the 4x4 multiplier. It captures the 8-bit product when the multiplier signals done and converts it to packed BCD with an iterative shift-add-3 (double-dabble) sequence, one bit per clock. The BCD result feeds the display/readout path. It uses the same start/busy/done flag style as the multiplier.

Parameters:
BIN_W, 8, width of binary input (multiplier product width)
DIGITS, 3, number of BCD output digits (4 bits each)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  convert request; sampled every edge, wired to multiplier done
bin_in  input  BIN_W  binary value to convert; sampled only on an accepted start
busy  output  1  high while conversion in progress
done  output  1  sticky completion flag; high from completion until next accepted start
bcd_out  output  4*DIGITS  packed BCD result, digit 0 (ones) in [3:0]; held between conversions
overflow  output  1  result did not fit in DIGITS digits; valid when done=1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: busy=0, done=0, bcd_out=0, overflow=0, state=IDLE, internal shift/scratch/counter=0. Reset mid-conversion aborts immediately; no partial result reaches bcd_out.
- FSM states: IDLE, SHIFT, DONE.
- IDLE or DONE, start=1 at an edge (accept edge):
  - load bin_in into shift register, clear BCD scratch and overflow scratch
  - set counter=BIN_W, busy=1, done=0
  - enter SHIFT
- IDLE or DONE, start=0: hold all outputs.
- SHIFT, each edge:
  - every scratch digit >=5 gets +3 (all digits corrected in parallel, from pre-shift values)
  - shift {scratch, shift reg} left one bit
  - a 1 shifted out of the scratch MSB sets overflow scratch
  - decrement counter
- Last shift (counter 1->0) on the same edge:
  - bcd_out = final scratch, overflow = overflow scratch
  - busy=0, done=1, enter DONE
- Latency: with the accept edge at E0, shifts occur on E1..E_BIN_W, and results plus done are visible after edge E_BIN_W. Default: 9 edges from start sampled to done.
- start while busy=1, including on the completion edge, is ignored. There is no queuing. bin_in is don't-care.
- Back-to-back: start in DONE is accepted. done drops and busy rises on that edge. bcd_out keeps the old value until the new completion.
- bcd_out, overflow: change only on a completion edge or reset.
- Digit arithmetic is 4-bit per digit, with no carry between digits beyond the shift.
- Default params: max input 255 (multiplier max 225), so overflow never asserts.
- Output digits never exceed 9.

Test Plan:
- Reset then idle 20 cycles with start=0 -> busy=0, done=0, bcd_out=0x000, overflow=0 throughout.
- bin_in=0xE1 (15*15), start pulse 1 cycle -> busy high for 8 cycles, done=1 after 9th edge, bcd_out=0x225, overflow=0; done stays high 10 further idle cycles.
- Sweep bin_in 0x00, 0x0F, 0x63, 0xFF -> bcd_out 0x000, 0x015, 0x099, 0x255 respectively, each exactly 9 edges after start.
- Start 0x0F, re-assert start with bin_in=0xFF at cycles 3 and on completion edge -> second starts ignored, result 0x015. Then start in DONE with 0xFF -> done drops next edge, bcd_out stays 0x015 until new done, then 0x255.
- Start 0xFF, assert rst at cycle 4 for 1 cycle -> all outputs 0 after reset edge, state IDLE. A subsequent start 0x2A gives 0x042.
- Override DIGITS=2: bin_in=0xFF -> done after 9 edges, overflow=1. bin_in=0x63 -> bcd_out=0x99, overflow=0.
